// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t : FSM state encoding (IDLE/RUN/DONE). Encoding 2'd3 is unused
//             and falls back to IDLE in the controller.
package serial_add_ctrl_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_full.sv
// full: gate-level 1-bit full-adder cell, purely combinational.
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module full (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic ab_x;
   logic ab_a;
   logic cx_a;

   xor g_x0 (ab_x, a, b);
   xor g_x1 (sum, ab_x, cin);
   and g_a0 (ab_a, a, b);
   and g_a1 (cx_a, ab_x, cin);
   or  g_o0 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. Adds two WIDTH-bit operands
// LSB first through one shared full-adder cell, one bit per clock.
//   clk    : system clock (rising edge)
//   rst_n  : synchronous active-low reset
//   start  : request, honoured only in IDLE or DONE
//   a, b   : operands, captured when start is accepted
//   cin    : carry-in, captured when start is accepted
//   busy   : high while the serial add is running
//   done   : one-cycle completion pulse
//   sum    : result register, updated only on completion
//   cout   : final carry-out, updated with sum
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic             c_reg;
   logic [CW-1:0]    cnt;

   logic             cell_sum;
   logic             cell_cout;
   logic [WIDTH:0]   r_ext;
   logic             last;
   logic             load;

   full u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (c_reg),
      .sum  (cell_sum),
      .cout (cell_cout)
   );

   // New result bit enters at the MSB; slicing the extended vector keeps
   // this legal for WIDTH=1 as well.
   assign r_ext = {cell_sum, r_sh};
   assign last  = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_nx = ST_IDLE;
      load     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = ST_RUN;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_RUN:  state_nx = last ? ST_DONE : ST_RUN;
         ST_DONE: begin
            // back-to-back accept keeps the pipe full when start is held
            if (start) begin
               load     = 1'b1;
               state_nx = ST_RUN;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         r_sh  <= '0;
         c_reg <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= state_nx;
         if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            c_reg <= cin;
            cnt   <= '0;
         end else if (state == ST_RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= r_ext[WIDTH:1];
            c_reg <= cell_cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
               sum  <= r_ext[WIDTH:1];
               cout <= cell_cout;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=1 instance run side by
// side against a timing/arithmetic model, plus directed literal checks.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       s8, c8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       s1, c1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int cmp  = 0;
   int mism = 0;
   bit chk_en = 1'b0;

   serial_add_ctrl #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

   serial_add_ctrl #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1), .cin(c1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         mism++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Model: an accepted add occupies WIDTH busy cycles, then one done cycle
   // in which {cout,sum} becomes a+b+cin; outputs hold until the next one.
   int         m8_left = 0, m1_left = 0;
   bit         m8_done = 0, m1_done = 0;
   logic [8:0] m8_res = '0, m8_out = '0;
   logic [1:0] m1_res = '0, m1_out = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m8_left = 0; m8_done = 0; m8_out = '0;
         m1_left = 0; m1_done = 0; m1_out = '0;
      end else begin
         m8_done = 0;
         if (m8_left > 0) begin
            m8_left--;
            if (m8_left == 0) begin m8_out = m8_res; m8_done = 1; end
         end else if (s8) begin
            m8_res  = {1'b0, a8} + {1'b0, b8} + 9'(c8);
            m8_left = 8;
         end
         m1_done = 0;
         if (m1_left > 0) begin
            m1_left--;
            if (m1_left == 0) begin m1_out = m1_res; m1_done = 1; end
         end else if (s1) begin
            m1_res  = {1'b0, a1} + {1'b0, b1} + 2'(c1);
            m1_left = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy8", 32'(busy8), 32'(m8_left > 0));
         chk("done8", 32'(done8), 32'(m8_done));
         chk("sum8",  32'(sum8),  32'(m8_out[7:0]));
         chk("cout8", 32'(cout8), 32'(m8_out[8]));
         chk("busy1", 32'(busy1), 32'(m1_left > 0));
         chk("done1", 32'(done1), 32'(m1_done));
         chk("sum1",  32'(sum1),  32'(m1_out[0]));
         chk("cout1", 32'(cout1), 32'(m1_out[1]));
      end
   end

   // Single add on the WIDTH=8 instance; optional mid-run start with a=0.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input bit mid, input logic [7:0] es, input logic ec,
                      input string nm);
      int k;
      bit got;
      @(negedge clk);
      s8 = 1'b1; a8 = a; b8 = b; c8 = c;
      @(posedge clk);
      k = 0; got = 0;
      while (k < 20 && !got) begin
         @(negedge clk);
         k++;
         if (k == 1) s8 = 1'b0;
         if (mid && k == 3) begin s8 = 1'b1; a8 = 8'h00; end
         if (mid && k == 4) s8 = 1'b0;
         if (done8) got = 1;
      end
      chk({nm, "_lat"},  32'(k), 32'd9);
      chk({nm, "_sum"},  32'(sum8), 32'(es));
      chk({nm, "_cout"}, 32'(cout8), 32'(ec));
   endtask

   logic [7:0] oa [3] = '{8'h01, 8'h80, 8'h7F};
   logic [7:0] ob [3] = '{8'h01, 8'h80, 8'h00};
   logic [7:0] es5[3] = '{8'h02, 8'h00, 8'h7F};
   logic       ec5[3] = '{1'b0, 1'b1, 1'b0};

   initial begin
      int k, nd;
      bit got;
      logic [2:0] vv;
      // reset wins over a pending start
      rst_n = 1'b0;
      s8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1;
      s1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_done8", 32'(done8), 32'd0);
      chk("rst_sum8",  32'(sum8),  32'd0);
      chk("rst_cout8", 32'(cout8), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      s8 = 1'b0; s1 = 1'b0;
      rst_n = 1'b1;
      chk_en = 1'b1;

      op8(8'h5A, 8'h3C, 1'b0, 0, 8'h96, 1'b0, "t1");
      op8(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, "t2a");
      op8(8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, "t2b");
      op8(8'h5A, 8'h3C, 1'b1, 1, 8'h97, 1'b0, "t3");
      nd = 0;
      repeat (10) begin @(negedge clk); if (done8) nd++; end
      chk("t3_extra_done", 32'(nd), 32'd0);

      // reset in the middle of a run
      @(negedge clk);
      s8 = 1'b1; a8 = 8'h33; b8 = 8'h44; c8 = 1'b0;
      @(posedge clk);
      @(negedge clk); s8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t4_busy", 32'(busy8), 32'd0);
      chk("t4_done", 32'(done8), 32'd0);
      chk("t4_sum",  32'(sum8),  32'd0);
      chk("t4_cout", 32'(cout8), 32'd0);
      rst_n = 1'b1;
      nd = 0;
      repeat (12) begin @(negedge clk); if (done8) nd++; end
      chk("t4_no_done", 32'(nd), 32'd0);

      // start held high: back-to-back adds every 9 cycles
      @(negedge clk);
      s8 = 1'b1; a8 = oa[0]; b8 = ob[0]; c8 = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         k = 0; got = 0;
         while (k < 20 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
               if (i < 2) begin a8 = oa[i+1]; b8 = ob[i+1]; end
               else s8 = 1'b0;
            end
            if (done8) got = 1;
         end
         chk("t5_lat",  32'(k), 32'd9);
         chk("t5_sum",  32'(sum8), 32'(es5[i]));
         chk("t5_cout", 32'(cout8), 32'(ec5[i]));
         if (i < 2) @(posedge clk);
      end
      repeat (3) @(negedge clk);

      // WIDTH=1 exhaustive sweep
      for (int v = 0; v < 8; v++) begin
         vv = v[2:0];
         @(negedge clk);
         s1 = 1'b1; a1 = vv[2]; b1 = vv[1]; c1 = vv[0];
         @(posedge clk);
         @(negedge clk);
         s1 = 1'b0;
         chk("t6_busy", 32'(busy1), 32'd1);
         @(negedge clk);
         chk("t6_done", 32'(done1), 32'd1);
         chk("t6_res",  32'({cout1, sum1}), 32'(vv[2]) + 32'(vv[1]) + 32'(vv[0]));
      end

      // random traffic on both instances, with occasional resets
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 80) != 0);
         s8 = ($urandom_range(0, 2) == 0);
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
         s1 = ($urandom_range(0, 1) == 0);
         a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      end
      @(negedge clk);
      s8 = 1'b0; s1 = 1'b0; rst_n = 1'b1;
      repeat (12) @(negedge clk);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
      $finish;
   end

endmodule
